// File: rtl/rv_decode_queue_if.sv
// Fetch-to-execute handshake bundle for the RV32I decode queue.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface rv_decode_queue_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_WIDTH-1:0] in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [6:0]          opcode;
    logic [4:0]          destination_reg;
    logic [2:0]          func3;
    logic [4:0]          source1_reg;
    logic [4:0]          source2_reg;
    logic [6:0]          func7;
    logic [XLEN-1:0]     imm;
    logic [2:0]          imm_type;
    logic                illegal;
    logic [PC_WIDTH-1:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, opcode, destination_reg, func3,
               source1_reg, source2_reg, func7, imm, imm_type, illegal, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, opcode, destination_reg, func3,
               source1_reg, source2_reg, func7, imm, imm_type, illegal, out_pc
    );
endinterface

// File: rtl/rv_decode_queue.sv
// RV32I decode stage: decodes each accepted instruction combinationally and buffers the
// decoded record in a DEPTH-entry FIFO between fetch and execute, with synchronous flush.
module rv_decode_queue #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    rv_decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Only the raw instruction is stored; the register/func fields are re-sliced at the head.
    typedef struct packed {
        logic [31:0]            instr;
        logic [PC_WIDTH-1:0]    pc;
        logic signed [XLEN-1:0] imm;
        imm_type_e              imm_type;
        logic                   illegal;
    } rec_t;

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic rec_t decode(input logic [31:0] i, input logic [PC_WIDTH-1:0] pc);
        rec_t             r;
        logic signed [31:0] raw;
        imm_type_e        t;
        logic             bad;
        logic [2:0]       f3;
        logic [6:0]       f7;
        raw = '0;
        t   = IMM_NONE;
        bad = 1'b0;
        f3  = i[14:12];
        f7  = i[31:25];
        case (i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                raw = {i[31:12], 12'b0};
                t   = IMM_U;
            end
            OPC_JAL: begin
                raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                t   = IMM_J;
            end
            OPC_BRANCH: begin
                raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                t   = IMM_B;
            end
            OPC_STORE: begin
                raw = {{20{i[31]}}, i[31:25], i[11:7]};
                t   = IMM_S;
            end
            OPC_JALR: begin
                raw = {{20{i[31]}}, i[31:20]};
                t   = IMM_I;
                bad = (f3 != 3'b000);
            end
            OPC_LOAD, OPC_FENCE, OPC_SYSTEM: begin
                raw = {{20{i[31]}}, i[31:20]};
                t   = IMM_I;
            end
            OPC_OPIMM: begin
                raw = {{20{i[31]}}, i[31:20]};
                t   = IMM_I;
                // Shift-immediates reuse the func7 slot; only SRAI may set bit 30.
                bad = ((f3 == 3'b001) && (f7 != F7_BASE)) ||
                      ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OPC_OP: begin
                bad = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            default: bad = 1'b1;
        endcase
        r.instr    = i;
        r.pc       = pc;
        r.illegal  = bad;
        r.imm_type = bad ? IMM_NONE : t;
        r.imm      = bad ? '0 : sext32(raw);
        return r;
    endfunction

    rec_t             mem [DEPTH];
    rec_t             in_rec;
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        in_rec = decode(bus.in_instr, bus.in_pc);
    end

    // Queue control: flush dominates any push or pop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the outputs read zero until the first record lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    // When empty, point at the most recently popped slot so outputs hold their last value.
    always_comb begin
        head_ptr = rd_ptr;
        if (count == '0) head_ptr = rd_ptr - PTR_W'(1);
        head = mem[head_ptr];
    end

    assign bus.opcode          = head.instr[6:0];
    assign bus.destination_reg = head.instr[11:7];
    assign bus.func3           = head.instr[14:12];
    assign bus.source1_reg     = head.instr[19:15];
    assign bus.source2_reg     = head.instr[24:20];
    assign bus.func7           = head.instr[31:25];
    assign bus.imm             = head.imm;
    assign bus.imm_type        = head.imm_type;
    assign bus.illegal         = head.illegal;
    assign bus.out_pc          = head.pc;
endmodule

// File: tb/tb_rv_decode_queue.sv
// Directed scoreboard bench for rv_decode_queue: expected decode results are queued on push
// and compared against the head record whenever a pop happens.
module tb_rv_decode_queue;
    logic clk;
    logic reset;
    logic flush;

    rv_decode_queue_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

    rv_decode_queue #(.XLEN(32), .PC_WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [2:0] typ, input logic ill);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        pend.instr   = instr;
        pend.pc      = pc;
        pend.imm     = imm;
        pend.typ     = typ;
        pend.ill     = ill;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
        bus.in_pc    = 32'h0;
    endtask

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_output", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
        chk("fields", 64'({bus.func7, bus.source2_reg, bus.source1_reg, bus.func3,
                           bus.destination_reg, bus.opcode}), 64'(e.instr));
        chk("imm", 64'(bus.imm), 64'(e.imm));
        chk("imm_type", 64'(bus.imm_type), 64'(e.typ));
        chk("illegal", 64'(bus.illegal), 64'(e.ill));
    endtask

    // Inputs are held from posedge+1; everything is sampled on the falling edge.
    task automatic cycle();
        @(negedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) check_head();
            if (bus.in_valid && bus.in_ready) sb.push_back(pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && (sb.size() != 0 || bus.out_valid); k++) cycle();
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_imm", 64'(bus.imm), 64'd0);
        chk("reset_out_pc", 64'(bus.out_pc), 64'd0);
        reset = 1'b0;
        cycle();

        // Immediate formats, streamed with the consumer always ready (push+pop at count 1)
        bus.out_ready = 1'b1;
        drive(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0);
        cycle();
        chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
        chk("latency_rd", 64'(bus.destination_reg), 64'd1);
        drive(32'h800000EF, 32'h104, 32'hFFF00000, 3'd5, 1'b0); cycle();
        chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
        chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
        drive(32'h123452B7, 32'h108, 32'h12345000, 3'd4, 1'b0); cycle();
        drive(32'hFE112E23, 32'h10C, 32'hFFFFFFFC, 3'd2, 1'b0); cycle();
        drive(32'h00000463, 32'h110, 32'h00000008, 3'd3, 1'b0); cycle();
        drive(32'hFE000EE3, 32'h114, 32'hFFFFFFFC, 3'd3, 1'b0); cycle();
        drive(32'h002081B3, 32'h118, 32'h00000000, 3'd0, 1'b0); cycle();
        drive(32'hFFFFF517, 32'h11C, 32'hFFFFF000, 3'd4, 1'b0); cycle();
        drive(32'h4010D093, 32'h120, 32'h00000401, 3'd1, 1'b0); cycle();
        chk("stream_count_one", 64'({bus.in_ready, bus.out_valid}), 64'd3);
        drain();

        // Backpressure: two fill the queue, the third waits for a pop and there is no bypass
        bus.out_ready = 1'b0;
        drive(32'h00400113, 32'h200, 32'h00000004, 3'd1, 1'b0); cycle();
        drive(32'h00812183, 32'h204, 32'h00000008, 3'd1, 1'b0); cycle();
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(32'hFFC0A203, 32'h208, 32'hFFFFFFFC, 3'd1, 1'b0); cycle();
        chk("full_held_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        chk("no_bypass_in_ready", 64'(bus.in_ready), 64'd0);
        cycle();
        chk("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        drain();

        // Flush with a full queue and a pending push
        bus.out_ready = 1'b0;
        drive(32'h00100093, 32'h300, 32'h00000001, 3'd1, 1'b0); cycle();
        drive(32'h00200093, 32'h304, 32'h00000002, 3'd1, 1'b0); cycle();
        drive(32'h00300093, 32'h308, 32'h00000003, 3'd1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("flush_dropped", 64'(bus.out_valid), 64'd0);

        // Flush beats a push that would otherwise be accepted
        drive(32'h00500093, 32'h310, 32'h00000005, 3'd1, 1'b0); cycle();
        drive(32'h00600093, 32'h314, 32'h00000006, 3'd1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        chk("flush_push_out_valid", 64'(bus.out_valid), 64'd0);
        drain();

        // Illegal encodings: fields pass through, imm and type forced to zero
        bus.out_ready = 1'b1;
        drive(32'h00000000, 32'h400, 32'h0, 3'd0, 1'b1); cycle();
        drive(32'hFE000033, 32'h404, 32'h0, 3'd0, 1'b1); cycle();
        drive(32'h00001067, 32'h408, 32'h0, 3'd0, 1'b1); cycle();
        drive(32'h02001013, 32'h40C, 32'h0, 3'd0, 1'b1); cycle();
        drive(32'h4000D013, 32'h410, 32'h00000400, 3'd1, 1'b0); cycle();
        drain();

        // Asynchronous reset in the middle of a transfer
        bus.out_ready = 1'b0;
        drive(32'hABC00093, 32'h500, 32'hFFFFFABC, 3'd1, 1'b0); cycle();
        drive(32'h12300093, 32'h504, 32'h00000123, 3'd1, 1'b0); cycle();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_reset_imm", 64'(bus.imm), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'h00700093, 32'h600, 32'h00000007, 3'd1, 1'b0); cycle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
